collision_event_handler: RTL and testbench

COLLISION_EVENT_HANDLER -- requirements
Module: collision_event_handler

---
 rtl/game_pkg.sv | 30 +++
 rtl/collision_event_handler_if.sv | 43 ++++
 rtl/player_stats.sv | 91 +++++++++
 rtl/collision_event_handler.sv | 106 ++++++++++
 tb/tb_collision_event_handler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and default parameters for the collision event handler.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam int DEF_INIT_LIVES    = 3;
  localparam int DEF_MAX_LIVES     = 7;
  localparam int DEF_GOLD_MAX      = 255;
  localparam int DEF_INVULN_FRAMES = 60;

  localparam int LIVES_W = 3;
  localparam int GOLD_W  = 8;

  // Width needed to hold the immunity counter value 0..frames.
  function automatic int imm_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/collision_event_handler_if.sv
// Event and status bundle between the game logic and the collision handler.
// Handshake: every event is a single-cycle pulse with no ready/backpressure;
// every status output is valid on every cycle (level semantics).
interface collision_event_handler_if;
  import game_pkg::*;

  logic                startOfFrame;
  logic                new_game;
  logic                death1;
  logic                death2;
  logic                more_gold1;
  logic                more_gold2;
  logic                more_life1;
  logic                more_life2;
  logic                tank1_mother2_collision;
  logic                tank2_mother1_collision;

  logic [LIVES_W-1:0]  lives1;
  logic [LIVES_W-1:0]  lives2;
  logic [GOLD_W-1:0]   gold1;
  logic [GOLD_W-1:0]   gold2;
  logic                invuln1;
  logic                invuln2;
  logic                playing;
  logic                game_over;
  logic [1:0]          winner;
  game_state_t         state_dbg;

  modport master (
    output startOfFrame, new_game, death1, death2, more_gold1, more_gold2,
           more_life1, more_life2, tank1_mother2_collision, tank2_mother1_collision,
    input  lives1, lives2, gold1, gold2, invuln1, invuln2, playing, game_over,
           winner, state_dbg
  );

  modport slave (
    input  startOfFrame, new_game, death1, death2, more_gold1, more_gold2,
           more_life1, more_life2, tank1_mother2_collision, tank2_mother1_collision,
    output lives1, lives2, gold1, gold2, invuln1, invuln2, playing, game_over,
           winner, state_dbg
  );

endinterface

// File: rtl/player_stats.sv
// Per-player pending event flags plus lives/gold/immunity counters.
// Flags collect pulses during a frame; counters update on startOfFrame.
module player_stats
  import game_pkg::*;
#(
  parameter int INIT_LIVES    = DEF_INIT_LIVES,
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int GOLD_MAX      = DEF_GOLD_MAX,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               active,
  input  logic               sof,
  input  logic               death,
  input  logic               more_gold,
  input  logic               more_life,
  input  logic               capture,
  output logic [LIVES_W-1:0] lives,
  output logic [GOLD_W-1:0]  gold,
  output logic               invuln,
  output logic               zero_next,
  output logic               capture_pend
);

  localparam int IMM_W = imm_width(INVULN_FRAMES);

  logic               pend_death, pend_gold, pend_life, pend_cap;
  logic [LIVES_W-1:0] lives_q, lives_nxt, after_death;
  logic [GOLD_W-1:0]  gold_q, gold_nxt;
  logic [IMM_W-1:0]   imm_q, imm_nxt;
  logic               death_hit;

  // Frame update: death first, then life (blocked if that death hit 0), gold saturating.
  always_comb begin
    death_hit   = pend_death && (imm_q == '0);
    after_death = lives_q;
    imm_nxt     = imm_q;
    if (death_hit) begin
      after_death = (lives_q == '0) ? '0 : lives_q - 1'b1;
      imm_nxt     = IMM_W'(INVULN_FRAMES);
    end else if (imm_q != '0) begin
      imm_nxt = imm_q - 1'b1;
    end
    lives_nxt = after_death;
    if (pend_life && !(death_hit && (after_death == '0)) &&
        (after_death < LIVES_W'(MAX_LIVES))) begin
      lives_nxt = after_death + 1'b1;
    end
    gold_nxt = gold_q;
    if (pend_gold && (gold_q < GOLD_W'(GOLD_MAX))) begin
      gold_nxt = gold_q + 1'b1;
    end
  end

  // Counters and sticky flags; a pulse on the startOfFrame cycle seeds the next frame.
  always_ff @(posedge clk) begin
    if (resetN || clear) begin
      lives_q    <= LIVES_W'(INIT_LIVES);
      gold_q     <= '0;
      imm_q      <= '0;
      pend_death <= 1'b0;
      pend_gold  <= 1'b0;
      pend_life  <= 1'b0;
      pend_cap   <= 1'b0;
    end else if (active) begin
      if (sof) begin
        lives_q    <= lives_nxt;
        gold_q     <= gold_nxt;
        imm_q      <= imm_nxt;
        pend_death <= death;
        pend_gold  <= more_gold;
        pend_life  <= more_life;
        pend_cap   <= capture;
      end else begin
        pend_death <= pend_death | death;
        pend_gold  <= pend_gold | more_gold;
        pend_life  <= pend_life | more_life;
        pend_cap   <= pend_cap | capture;
      end
    end
  end

  assign lives        = lives_q;
  assign gold         = gold_q;
  assign invuln       = (imm_q != '0);
  assign zero_next    = (lives_nxt == '0);
  assign capture_pend = pend_cap;

endmodule

// File: rtl/collision_event_handler.sv
// Game state machine: IDLE -> PLAY -> OVER with winner decision at frame boundaries.
module collision_event_handler
  import game_pkg::*;
#(
  parameter int INIT_LIVES    = DEF_INIT_LIVES,
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int GOLD_MAX      = DEF_GOLD_MAX,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input logic                      clk,
  input logic                      resetN,
  collision_event_handler_if.slave bus
);

  game_state_t        state_q, state_d;
  winner_t            winner_q, winner_d;
  logic               clear_stats, active;
  logic               zero1, zero2, cap1, cap2, p1_lose, p2_lose;
  logic [LIVES_W-1:0] lives1_w, lives2_w;
  logic [GOLD_W-1:0]  gold1_w, gold2_w;
  logic               inv1_w, inv2_w;

  assign active  = (state_q == ST_PLAY);
  // Player 1 loses on its own last life or when player 2 reaches player 1's base.
  assign p1_lose = zero1 | cap2;
  assign p2_lose = zero2 | cap1;

  player_stats #(
    .INIT_LIVES(INIT_LIVES), .MAX_LIVES(MAX_LIVES),
    .GOLD_MAX(GOLD_MAX), .INVULN_FRAMES(INVULN_FRAMES)
  ) u_p1 (
    .clk(clk), .resetN(resetN), .clear(clear_stats), .active(active),
    .sof(bus.startOfFrame), .death(bus.death1), .more_gold(bus.more_gold1),
    .more_life(bus.more_life1), .capture(bus.tank1_mother2_collision),
    .lives(lives1_w), .gold(gold1_w), .invuln(inv1_w),
    .zero_next(zero1), .capture_pend(cap1)
  );

  player_stats #(
    .INIT_LIVES(INIT_LIVES), .MAX_LIVES(MAX_LIVES),
    .GOLD_MAX(GOLD_MAX), .INVULN_FRAMES(INVULN_FRAMES)
  ) u_p2 (
    .clk(clk), .resetN(resetN), .clear(clear_stats), .active(active),
    .sof(bus.startOfFrame), .death(bus.death2), .more_gold(bus.more_gold2),
    .more_life(bus.more_life2), .capture(bus.tank2_mother1_collision),
    .lives(lives2_w), .gold(gold2_w), .invuln(inv2_w),
    .zero_next(zero2), .capture_pend(cap2)
  );

  // Next-state and winner decode; new_game only matters outside PLAY.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    clear_stats = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.new_game) begin
          state_d     = ST_PLAY;
          winner_d    = WIN_NONE;
          clear_stats = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.startOfFrame) begin
          if (p1_lose && p2_lose) begin
            state_d  = ST_OVER;
            winner_d = WIN_DRAW;
          end else if (p1_lose) begin
            state_d  = ST_OVER;
            winner_d = WIN_P2;
          end else if (p2_lose) begin
            state_d  = ST_OVER;
            winner_d = WIN_P1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        winner_d = WIN_NONE;
      end
    endcase
  end

  // State and winner registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q  <= ST_IDLE;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  assign bus.lives1    = lives1_w;
  assign bus.lives2    = lives2_w;
  assign bus.gold1     = gold1_w;
  assign bus.gold2     = gold2_w;
  assign bus.invuln1   = inv1_w;
  assign bus.invuln2   = inv2_w;
  assign bus.playing   = (state_q == ST_PLAY);
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.winner    = winner_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_collision_event_handler.sv
// Directed bench for collision_event_handler with an expected-value queue.
// Snapshot layout: {lives1, lives2, gold1, gold2, invuln1, invuln2, playing, game_over, winner}.
module tb_collision_event_handler;
  import game_pkg::*;

  localparam int E_D1 = 0, E_D2 = 1, E_G1 = 2, E_G2 = 3;
  localparam int E_L1 = 4, E_L2 = 5, E_T1M2 = 6, E_T2M1 = 7;

  logic clk;
  logic resetN;
  logic chk;
  int   tests;
  int   failed;

  logic [27:0] exp_q[$];
  string       name_q[$];
  logic [27:0] act;

  collision_event_handler_if bus();

  collision_event_handler dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  assign act = {bus.lives1, bus.lives2, bus.gold1, bus.gold2, bus.invuln1,
                bus.invuln2, bus.playing, bus.game_over, bus.winner};

  function automatic logic [27:0] mk(input int l1, input int l2, input int g1,
                                     input int g2, input int i1, input int i2,
                                     input int pl, input int go, input int w);
    return {3'(l1), 3'(l2), 8'(g1), 8'(g2), 1'(i1), 1'(i2), 1'(pl), 1'(go), 2'(w)};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    bus.death1 = 0; bus.death2 = 0;
    bus.more_gold1 = 0; bus.more_gold2 = 0;
    bus.more_life1 = 0; bus.more_life2 = 0;
    bus.tank1_mother2_collision = 0; bus.tank2_mother1_collision = 0;
  endtask

  task automatic set_ev(input int which);
    case (which)
      E_D1:    bus.death1 = 1;
      E_D2:    bus.death2 = 1;
      E_G1:    bus.more_gold1 = 1;
      E_G2:    bus.more_gold2 = 1;
      E_L1:    bus.more_life1 = 1;
      E_L2:    bus.more_life2 = 1;
      E_T1M2:  bus.tank1_mother2_collision = 1;
      default: bus.tank2_mother1_collision = 1;
    endcase
  endtask

  task automatic fire();
    tick();
    clear_ev();
  endtask

  task automatic pulse_sof();
    bus.startOfFrame = 1;
    tick();
    bus.startOfFrame = 0;
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1;
    tick();
    bus.new_game = 0;
  endtask

  task automatic idle_frames(input int n);
    repeat (n) begin
      tick();
      pulse_sof();
    end
  endtask

  task automatic check_out(input string name, input logic [27:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
    chk = 1;
    tick();
    chk = 0;
  endtask

  // Scoreboard monitor: pops one expectation per presented snapshot
  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL no_expectation: actual=%h with empty queue", act);
      end else begin
        logic [27:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (act !== e) begin
          failed++;
          $display("FAIL %s: actual=%h required=%h", n, act, e);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    tests  = 0;
    failed = 0;
    chk    = 0;
    resetN = 1;
    bus.startOfFrame = 0;
    bus.new_game = 0;
    clear_ev();
    tick();
    tick();
    resetN = 0;
    check_out("reset_state", mk(3, 3, 0, 0, 0, 0, 0, 0, 0));

    // Events in IDLE are ignored
    set_ev(E_D1); set_ev(E_G1); fire();
    pulse_sof();
    check_out("idle_ignores", mk(3, 3, 0, 0, 0, 0, 0, 0, 0));

    pulse_new_game();
    check_out("new_game_play", mk(3, 3, 0, 0, 0, 0, 1, 0, 0));

    // Ten deaths in one frame count once; new_game in PLAY ignored
    for (int i = 0; i < 10; i++) begin
      set_ev(E_D1); fire();
    end
    pulse_new_game();
    pulse_sof();
    check_out("ten_deaths_one", mk(2, 3, 0, 0, 1, 0, 1, 0, 0));

    // Deaths while immune are discarded
    for (int f = 1; f <= 60; f++) begin
      if (f == 1 || f == 30) begin
        set_ev(E_D1); fire();
      end
      pulse_sof();
      if (f == 30) check_out("immune_f30", mk(2, 3, 0, 0, 1, 0, 1, 0, 0));
      if (f == 59) check_out("immune_f59", mk(2, 3, 0, 0, 1, 0, 1, 0, 0));
    end
    check_out("immune_expired", mk(2, 3, 0, 0, 0, 0, 1, 0, 0));
    set_ev(E_D1); fire();
    pulse_sof();
    check_out("death_f61", mk(1, 3, 0, 0, 1, 0, 1, 0, 0));

    // Gold saturation and life saturation
    for (int k = 1; k <= 300; k++) begin
      set_ev(E_G2);
      if (k <= 8) set_ev(E_L1);
      fire();
      pulse_sof();
      if (k == 6)   check_out("life_reach7", mk(7, 3, 0, 6, 1, 0, 1, 0, 0));
      if (k == 8)   check_out("life_sat7", mk(7, 3, 0, 8, 1, 0, 1, 0, 0));
      if (k == 100) check_out("gold_100", mk(7, 3, 0, 100, 0, 0, 1, 0, 0));
    end
    check_out("gold_sat255", mk(7, 3, 0, 255, 0, 0, 1, 0, 0));

    // Death and life in the same frame: 7 -> 6 -> 7
    set_ev(E_D1); set_ev(E_L1); fire();
    pulse_sof();
    check_out("death_then_life", mk(7, 3, 0, 255, 1, 0, 1, 0, 0));

    // Capture coincident with startOfFrame lands in the next frame
    bus.tank1_mother2_collision = 1;
    bus.startOfFrame = 1;
    tick();
    bus.tank1_mother2_collision = 0;
    bus.startOfFrame = 0;
    check_out("capture_deferred", mk(7, 3, 0, 255, 1, 0, 1, 0, 0));
    pulse_sof();
    check_out("capture_p1_wins", mk(7, 3, 0, 255, 1, 0, 0, 1, 1));

    // OVER freezes everything
    set_ev(E_D2); set_ev(E_G1); fire();
    pulse_sof();
    check_out("over_frozen", mk(7, 3, 0, 255, 1, 0, 0, 1, 1));

    pulse_new_game();
    check_out("restart", mk(3, 3, 0, 0, 0, 0, 1, 0, 0));

    // Both players run out of lives in the same frame
    set_ev(E_D1); set_ev(E_D2); fire();
    pulse_sof();
    check_out("both_die_2", mk(2, 2, 0, 0, 1, 1, 1, 0, 0));
    idle_frames(60);
    check_out("both_immune_end", mk(2, 2, 0, 0, 0, 0, 1, 0, 0));
    set_ev(E_D1); set_ev(E_D2); fire();
    pulse_sof();
    check_out("both_die_1", mk(1, 1, 0, 0, 1, 1, 1, 0, 0));
    idle_frames(60);
    set_ev(E_D1); set_ev(E_D2); fire();
    pulse_sof();
    check_out("draw", mk(0, 0, 0, 0, 1, 1, 0, 1, 3));
    set_ev(E_L1); set_ev(E_G2); set_ev(E_T2M1); fire();
    pulse_sof();
    check_out("draw_frozen", mk(0, 0, 0, 0, 1, 1, 0, 1, 3));

    // Player 2 captures player 1's base
    pulse_new_game();
    set_ev(E_T2M1); fire();
    pulse_sof();
    check_out("capture_p2_wins", mk(3, 3, 0, 0, 0, 0, 0, 1, 2));

    // Mid-frame reset with pending flags
    pulse_new_game();
    check_out("play_again", mk(3, 3, 0, 0, 0, 0, 1, 0, 0));
    set_ev(E_D1); set_ev(E_G1); set_ev(E_L2); fire();
    resetN = 1;
    tick();
    resetN = 0;
    check_out("midframe_reset", mk(3, 3, 0, 0, 0, 0, 0, 0, 0));
    pulse_sof();
    check_out("reset_no_update", mk(3, 3, 0, 0, 0, 0, 0, 0, 0));

    // Reset wins over new_game and startOfFrame
    resetN = 1;
    bus.new_game = 1;
    bus.startOfFrame = 1;
    tick();
    resetN = 0;
    bus.new_game = 0;
    bus.startOfFrame = 0;
    check_out("reset_priority", mk(3, 3, 0, 0, 0, 0, 0, 0, 0));

    // Report
    tick();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
